// File: rtl/conv_ctrl_pkg.sv
// Shared types and elaboration helpers for the convolution window sequencer.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN} state_t;

  function automatic int clog2(input int n);
    int b;
    b = 0;
    while ((1 << b) < n) b++;
    return b;
  endfunction

  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;
  localparam int DEF_K      = 3;
  localparam int DEF_STRIDE = 1;
  localparam int OUT_W = out_dim(DEF_IMG_W, DEF_K, DEF_STRIDE);
  localparam int OUT_H = out_dim(DEF_IMG_H, DEF_K, DEF_STRIDE);

endpackage

// File: rtl/raster_counter.sv
// Input-raster row/col tracker with stride-phase bookkeeping; flags window-aligned
// pixels and the last pixel of the frame.
module raster_counter #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int CW     = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  output logic qual,
  output logic last
);

  localparam logic PH_STEP = (STRIDE == 2);

  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_rph;
  logic          r_cph;
  logic          w_col_end;
  logic          w_row_on;
  logic          w_col_on;

  assign w_col_end = (r_col == CW'(IMG_W - 1));
  assign w_row_on  = (r_row >= CW'(K - 1));
  assign w_col_on  = (r_col >= CW'(K - 1));
  assign qual      = w_row_on && w_col_on && !r_rph && !r_cph;
  assign last      = (r_row == CW'(IMG_H - 1)) && w_col_end;

  // Phases count (pos-(K-1)) mod STRIDE; they only start moving once the window edge is reached
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_row <= '0;
      r_col <= '0;
      r_rph <= 1'b0;
      r_cph <= 1'b0;
    end else if (adv) begin
      if (w_col_end) begin
        r_col <= '0;
        r_cph <= 1'b0;
        r_row <= last ? '0 : r_row + 1'b1;
        if (w_row_on) r_rph <= r_rph ^ PH_STEP;
      end else begin
        r_col <= r_col + 1'b1;
        if (w_col_on) r_cph <= r_cph ^ PH_STEP;
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the conv line-buffer datapath: drives shift/clear controls
// and presents stride-aligned KxK windows to the MAC stage with valid/ready.
module conv_window_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int CW     = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_vld,
  output logic          in_rdy,
  output logic          lb_shift,
  output logic          lb_clr,
  output logic          win_vld,
  input  logic          win_rdy,
  output logic [CW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          busy,
  output logic          frame_done
);

  localparam int N_OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int MAX_DIM = (IMG_W > IMG_H) ? IMG_W : IMG_H;

  if ((clog2(MAX_DIM + 1) > CW) || (STRIDE < 1) || (STRIDE > 2)) begin : g_param_chk
    $error("conv_window_ctrl: CW too narrow or STRIDE outside 1..2");
  end

  state_t        r_state;
  logic [CW-1:0] r_orow;
  logic [CW-1:0] r_ocol;
  logic          w_qual;
  logic          w_last;
  logic          w_take;
  logic          w_clr;

  // A pending, unaccepted window freezes the stream so the datapath stays aligned with it
  assign in_rdy   = (r_state == S_RUN) && !(win_vld && !win_rdy);
  assign lb_shift = in_vld && in_rdy;
  assign w_take   = lb_shift && w_qual;
  assign w_clr    = (r_state == S_CLR);

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .STRIDE(STRIDE),
    .CW    (CW)
  ) u_raster (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .adv (lb_shift),
    .qual(w_qual),
    .last(w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      lb_clr     <= 1'b0;
      win_vld    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      r_orow     <= '0;
      r_ocol     <= '0;
    end else begin
      lb_clr     <= 1'b0;
      frame_done <= 1'b0;
      if (win_vld && win_rdy) win_vld <= 1'b0;
      // A new window on the handshake edge overrides the clear above
      if (w_take) begin
        win_vld <= 1'b1;
        win_row <= r_orow;
        win_col <= r_ocol;
        if (r_ocol == CW'(N_OUT_W - 1)) begin
          r_ocol <= '0;
          r_orow <= r_orow + 1'b1;
        end else begin
          r_ocol <= r_ocol + 1'b1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CLR;
            lb_clr  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_CLR: begin
          r_state <= S_RUN;
          r_orow  <= '0;
          r_ocol  <= '0;
        end
        S_RUN: begin
          if (lb_shift && w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!win_vld || win_rdy) begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: a 5x5/stride-1 instance and a 6x6/stride-2 instance.
module tb_conv_window_ctrl;

  logic clk;
  logic rst;
  logic start1, start2;
  logic in_vld;
  logic win_rdy;

  logic       in_rdy1, lb_shift1, lb_clr1, win_vld1, busy1, frame_done1;
  logic [5:0] win_row1, win_col1;
  logic       in_rdy2, lb_shift2, lb_clr2, win_vld2, busy2, frame_done2;
  logic [5:0] win_row2, win_col2;

  conv_window_ctrl #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(1), .CW(6)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .in_vld(in_vld), .in_rdy(in_rdy1),
    .lb_shift(lb_shift1), .lb_clr(lb_clr1), .win_vld(win_vld1), .win_rdy(win_rdy),
    .win_row(win_row1), .win_col(win_col1), .busy(busy1), .frame_done(frame_done1)
  );

  conv_window_ctrl #(.IMG_W(6), .IMG_H(6), .K(3), .STRIDE(2), .CW(6)) u_d2 (
    .clk(clk), .rst(rst), .start(start2), .in_vld(in_vld), .in_rdy(in_rdy2),
    .lb_shift(lb_shift2), .lb_clr(lb_clr2), .win_vld(win_vld2), .win_rdy(win_rdy),
    .win_row(win_row2), .win_col(win_col2), .busy(busy2), .frame_done(frame_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    else n_pass++;
  endtask

  // Monitor state, sampled mid-cycle (inputs change just after posedge)
  int         cyc = 0;
  logic [11:0] wq1[$];
  int         aq1[$];
  int         sh1, dn1, cl1, stall1, viol1, hs_cyc1, dn_cyc1;
  bit         stall_prev1;
  logic [11:0] stall_rc1;
  logic [11:0] wq2[$];
  int         aq2[$];
  int         sh2, dn2;

  always @(negedge clk) begin
    cyc++;
    if (win_vld1 && win_rdy) begin
      wq1.push_back({win_row1, win_col1});
      aq1.push_back(sh1);
      hs_cyc1 = cyc;
    end
    if (win_vld1 && !win_rdy) begin
      stall1++;
      if (in_rdy1 || lb_shift1) viol1++;
      if (stall_prev1 && ({win_row1, win_col1} != stall_rc1)) viol1++;
      stall_rc1 = {win_row1, win_col1};
    end
    stall_prev1 = win_vld1 && !win_rdy;
    if (lb_shift1) sh1++;
    if (frame_done1) begin dn1++; dn_cyc1 = cyc; end
    if (lb_clr1) cl1++;
    if (win_vld2 && win_rdy) begin
      wq2.push_back({win_row2, win_col2});
      aq2.push_back(sh2);
    end
    if (lb_shift2) sh2++;
    if (frame_done2) dn2++;
  end

  task automatic clr_mon1();
    wq1.delete(); aq1.delete();
    sh1 = 0; dn1 = 0; cl1 = 0; stall1 = 0; viol1 = 0; hs_cyc1 = 0; dn_cyc1 = 0;
    stall_prev1 = 1'b0; stall_rc1 = '0;
  endtask

  task automatic start_frame1(input string tag);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    chk({tag, "_lb_clr"}, lb_clr1, 1'b1);
  endtask

  // mode: 0 plain, 1 stall 5 cycles on first window, 2 random in_vld, 3 rst at pixel 10, 4 start mid-frame
  task automatic run1(input int mode, input string tag);
    int  d0;
    bit  stalled;
    bit  kicked;
    d0 = dn1; stalled = 0; kicked = 0;
    for (int c = 0; c < 400 && dn1 == d0; c++) begin
      @(posedge clk); #1;
      in_vld = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1 && !stalled && win_vld1) begin
        win_rdy = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        win_rdy = 1'b1;
        stalled = 1;
      end
      if (mode == 3 && sh1 >= 10) begin
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        break;
      end
      if (mode == 4 && !kicked && sh1 >= 5) begin
        start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        kicked = 1;
      end
    end
    in_vld = 1'b1;
    if (mode != 3) chk({tag, "_done_once"}, dn1 - d0, 1);
  endtask

  task automatic chk_order1(input string tag);
    logic [11:0] got;
    chk({tag, "_nwin"}, wq1.size(), 9);
    for (int i = 0; i < 9; i++) begin
      got = (i < wq1.size()) ? wq1[i] : 12'hfff;
      chk($sformatf("%s_win%0d", tag, i), got, 12'((i / 3) << 6 | (i % 3)));
    end
  endtask

  initial begin
    int   d0;
    logic [11:0] exp2 [4];
    int   acc2 [4];
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; in_vld = 1'b1; win_rdy = 1'b1;
    clr_mon1();
    sh2 = 0; dn2 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ctrl", {in_rdy1, lb_shift1, lb_clr1, win_vld1, busy1, frame_done1}, 6'b0);
    chk("rst_idx", {win_row1, win_col1}, 12'd0);
    chk("rst_ctrl2", {in_rdy2, lb_shift2, lb_clr2, win_vld2, busy2, frame_done2}, 6'b0);

    // 5x5 stride 1, continuous stream
    clr_mon1();
    start_frame1("s1");
    chk("s1_busy", busy1, 1'b1);
    run1(0, "s1");
    chk("s1_shifts", sh1, 25);
    chk_order1("s1");
    chk("s1_first_win_after_px", (aq1.size() > 0) ? aq1[0] : -1, 13);
    chk("s1_done_latency", dn_cyc1 - hs_cyc1, 1);
    chk("s1_busy_end", busy1, 1'b0);
    chk("s1_clr_count", cl1, 1);

    // 6x6 stride 2
    wq2.delete(); aq2.delete(); sh2 = 0; dn2 = 0;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    chk("s2_lb_clr", lb_clr2, 1'b1);
    d0 = dn2;
    for (int c = 0; c < 400 && dn2 == d0; c++) @(posedge clk);
    #1;
    chk("s2_done_once", dn2 - d0, 1);
    chk("s2_shifts", sh2, 36);
    chk("s2_nwin", wq2.size(), 4);
    exp2 = '{12'h000, 12'h001, 12'h040, 12'h041};
    acc2 = '{15, 17, 27, 29};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s2_win%0d", i), (i < wq2.size()) ? wq2[i] : 12'hfff, exp2[i]);
      chk($sformatf("s2_px%0d", i), (i < aq2.size()) ? aq2[i] : -1, acc2[i]);
    end

    // Backpressure: win_rdy low for 5 cycles on the first window
    clr_mon1();
    start_frame1("s3");
    run1(1, "s3");
    chk("s3_stall_cycles", stall1, 5);
    chk("s3_stall_hold_violations", viol1, 0);
    chk("s3_shifts", sh1, 25);
    chk_order1("s3");

    // Random in_vld
    clr_mon1();
    start_frame1("s4");
    run1(2, "s4");
    chk("s4_shifts", sh1, 25);
    chk_order1("s4");

    // rst mid-frame then a fresh frame
    clr_mon1();
    start_frame1("s5a");
    run1(3, "s5a");
    chk("s5_rst_ctrl", {in_rdy1, lb_shift1, lb_clr1, win_vld1, busy1, frame_done1}, 6'b0);
    chk("s5_rst_idx", {win_row1, win_col1}, 12'd0);
    clr_mon1();
    start_frame1("s5b");
    run1(0, "s5b");
    chk("s5_shifts", sh1, 25);
    chk_order1("s5");

    // start while busy is ignored
    clr_mon1();
    start_frame1("s6");
    run1(4, "s6");
    chk("s6_clr_count", cl1, 1);
    chk("s6_shifts", sh1, 25);
    chk_order1("s6");

    repeat (3) @(posedge clk);
    chk("end_dn1_quiet", dn1, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
